// File: rtl/vi_pkg.sv
// Shared integer-pipeline definitions: opcodes, function codes and widths
// used by the issue stage and its scoreboard.
package vi_pkg;

   localparam int XLEN       = 64;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CNT_W      = 32;

   localparam logic [6:0] OPC_REG = 7'b0110011;
   localparam logic [6:0] OPC_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SUB = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [6:0] F7_SLL = 7'b0000000;

   typedef enum logic [1:0] {
      OPK_REG = 2'd0,
      OPK_IMM = 2'd1,
      OPK_ILL = 2'd2
   } opk_e;

   function automatic opk_e decode_opk(input logic [6:0] opc);
      case (opc)
         OPC_REG: return OPK_REG;
         OPC_IMM: return OPK_IMM;
         default: return OPK_ILL;
      endcase
   endfunction

endpackage

// File: rtl/int_scoreboard.sv
// Per-register busy bits for in-flight producers. x0 is never busy; a set and
// a clear of the same register in one cycle leaves it busy (newer producer wins).
module int_scoreboard #(
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic          clk_i,
   input  logic          rsn_i,
   input  logic          flush_i,
   input  logic          set_en_i,
   input  logic [AW-1:0] set_addr_i,
   input  logic          clr_en_i,
   input  logic [AW-1:0] clr_addr_i,
   input  logic [AW-1:0] look_a_i,
   input  logic [AW-1:0] look_b_i,
   output logic          busy_a_o,
   output logic          busy_b_o
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_set_mask;
   logic [NREG-1:0] w_clr_mask;
   logic [NREG-1:0] w_busy_nxt;

   // Next busy vector: clear applied before set so the set dominates.
   always_comb begin
      w_set_mask = set_en_i ? (NREG'(1) << set_addr_i) : {NREG{1'b0}};
      w_clr_mask = clr_en_i ? (NREG'(1) << clr_addr_i) : {NREG{1'b0}};
      if (flush_i) begin
         w_busy_nxt = {NREG{1'b0}};
      end else begin
         w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREG'(1);
      end
   end

   // Busy register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         r_busy <= {NREG{1'b0}};
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   assign busy_a_o = r_busy[look_a_i];
   assign busy_b_o = r_busy[look_b_i];

endmodule

// File: rtl/int_issue.sv
// Decode/issue stage in front of int_alu: operand read with writeback bypass,
// RAW hazard stall via scoreboard, registered operands and stall counter.
module int_issue #(
   parameter int XLEN  = 64,
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rsn_i,
   input  logic             dec_valid_i,
   input  logic [31:0]      dec_instr_i,
   output logic             dec_ready_o,
   output logic [4:0]       rf_raddr_a_o,
   output logic [4:0]       rf_raddr_b_o,
   input  logic [XLEN-1:0]  rf_rdata_a_i,
   input  logic [XLEN-1:0]  rf_rdata_b_i,
   input  logic             wb_valid_i,
   input  logic [4:0]       wb_addr_i,
   input  logic [XLEN-1:0]  wb_data_i,
   input  logic             flush_i,
   output logic             alu_valid_o,
   output logic [31:0]      alu_instr_o,
   output logic [XLEN-1:0]  alu_data_a_o,
   output logic [XLEN-1:0]  alu_data_b_o,
   output logic [4:0]       alu_rd_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   import vi_pkg::*;

   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   opk_e            w_opk;
   logic            w_is_reg;
   logic            w_supp;
   logic            w_byp_a;
   logic            w_byp_b;
   logic            w_busy_a;
   logic            w_busy_b;
   logic            w_stall;
   logic            w_xfer;
   logic            w_issue;
   logic            w_ill;
   logic [XLEN-1:0] w_opnd_a;
   logic [XLEN-1:0] w_opnd_b;
   logic [XLEN-1:0] w_data_b;

   logic             r_valid;
   logic [31:0]      r_instr;
   logic [XLEN-1:0]  r_data_a;
   logic [XLEN-1:0]  r_data_b;
   logic [4:0]       r_rd;
   logic             r_ill;
   logic [CNT_W-1:0] r_stall_cnt;

   assign w_rs1    = dec_instr_i[19:15];
   assign w_rs2    = dec_instr_i[24:20];
   assign w_rd     = dec_instr_i[11:7];
   assign w_opk    = decode_opk(dec_instr_i[6:0]);
   assign w_is_reg = (w_opk == OPK_REG);
   assign w_supp   = (w_opk != OPK_ILL);

   // Operand selection, immediate extension and hazard/handshake decisions.
   always_comb begin
      w_byp_a = wb_valid_i && (wb_addr_i == w_rs1) && (w_rs1 != 5'd0);
      w_byp_b = wb_valid_i && (wb_addr_i == w_rs2) && (w_rs2 != 5'd0);
      if (w_rs1 == 5'd0) begin
         w_opnd_a = {XLEN{1'b0}};
      end else if (w_byp_a) begin
         w_opnd_a = wb_data_i;
      end else begin
         w_opnd_a = rf_rdata_a_i;
      end
      if (w_rs2 == 5'd0) begin
         w_opnd_b = {XLEN{1'b0}};
      end else if (w_byp_b) begin
         w_opnd_b = wb_data_i;
      end else begin
         w_opnd_b = rf_rdata_b_i;
      end
      if (w_is_reg) begin
         w_data_b = w_opnd_b;
      end else begin
         w_data_b = {{(XLEN-12){dec_instr_i[31]}}, dec_instr_i[31:20]};
      end
      // Illegal opcodes skip the hazard check; flush forces ready high.
      w_stall = dec_valid_i && w_supp && !flush_i &&
                ((w_busy_a && !w_byp_a) || (w_is_reg && w_busy_b && !w_byp_b));
      w_xfer  = dec_valid_i && !w_stall && !flush_i;
      w_issue = w_xfer && w_supp;
      w_ill   = w_xfer && !w_supp;
   end

   int_scoreboard #(
      .NREG (NREG),
      .AW   (5)
   ) u_sb (
      .clk_i      (clk_i),
      .rsn_i      (rsn_i),
      .flush_i    (flush_i),
      .set_en_i   (w_issue),
      .set_addr_i (w_rd),
      .clr_en_i   (wb_valid_i),
      .clr_addr_i (wb_addr_i),
      .look_a_i   (w_rs1),
      .look_b_i   (w_rs2),
      .busy_a_o   (w_busy_a),
      .busy_b_o   (w_busy_b)
   );

   // ALU-side output register and saturating stall counter.
   always_ff @(posedge clk_i) begin
      if (rsn_i) begin
         r_valid     <= 1'b0;
         r_instr     <= 32'd0;
         r_data_a    <= {XLEN{1'b0}};
         r_data_b    <= {XLEN{1'b0}};
         r_rd        <= 5'd0;
         r_ill       <= 1'b0;
         r_stall_cnt <= {CNT_W{1'b0}};
      end else begin
         r_valid <= w_issue;
         r_ill   <= w_ill;
         if (w_issue) begin
            r_instr  <= dec_instr_i;
            r_data_a <= w_opnd_a;
            r_data_b <= w_data_b;
            r_rd     <= w_rd;
         end
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign dec_ready_o  = !w_stall;
   assign rf_raddr_a_o = w_rs1;
   assign rf_raddr_b_o = w_rs2;
   assign alu_valid_o  = r_valid;
   assign alu_instr_o  = r_instr;
   assign alu_data_a_o = r_data_a;
   assign alu_data_b_o = r_data_b;
   assign alu_rd_o     = r_rd;
   assign illegal_o    = r_ill;
   assign stall_cnt_o  = r_stall_cnt;

endmodule
